// File: rtl/mips_cpu.sv
// Single-cycle KGP-RISC (MIPS subset) CPU: instruction memory, register bank, data memory and
// datapath in one clock period. Only the rt read bus is visible at the top level.

module mips_imem #(
    parameter int DEPTH = 64
) (
    input  logic [31:0] addr,
    output logic [31:0] instr
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] imem [0:DEPTH-1];
    logic        unused_addr;

    // Contents are preloaded from outside; the core never writes program memory.
    assign instr       = imem[addr[AW+1:2]];
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
endmodule

module mips_dmem #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] dmem [0:DEPTH-1];
    logic        unused_addr;

    always_ff @(posedge clk) begin
        if (we) begin
            dmem[addr[AW+1:2]] <= wd;
        end
    end

    assign rd          = dmem[addr[AW+1:2]];
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
endmodule

module mips_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regfile [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regfile[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regfile[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regfile[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regfile[ra2];
endmodule

module mips_datapath #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] writedata
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    logic [31:0] pc, pc_plus4, pc_next, instr;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wa;
    logic [31:0] imm_s, imm_z, rs_val, rt_val, src_b, alu_y, mem_rd, wd;
    logic        reg_we, mem_we, is_load, use_imm, zero_ext, branch, jump;
    alu_op_t     alu_op;

    function automatic logic [31:0] alu(input alu_op_t f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'd0, (sa < sb)};
            default: return a + b;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

    mips_imem #(.DEPTH(IMEM_DEPTH)) imem (.addr(pc), .instr(instr));

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];
    assign imm_s = {{16{instr[15]}}, instr[15:0]};
    assign imm_z = {16'd0, instr[15:0]};

    // Unknown opcodes and functs keep all write enables low, so they retire as NOPs.
    always_comb begin
        reg_we   = 1'b0;
        mem_we   = 1'b0;
        is_load  = 1'b0;
        use_imm  = 1'b0;
        zero_ext = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        alu_op   = ALU_ADD;
        wa       = rt;
        case (op)
            6'h00: begin
                wa     = rd;
                reg_we = 1'b1;
                case (funct)
                    6'h20:   alu_op = ALU_ADD;
                    6'h22:   alu_op = ALU_SUB;
                    6'h24:   alu_op = ALU_AND;
                    6'h25:   alu_op = ALU_OR;
                    6'h2A:   alu_op = ALU_SLT;
                    default: reg_we = 1'b0;
                endcase
            end
            6'h08: begin reg_we = 1'b1; use_imm = 1'b1; end
            6'h0C: begin reg_we = 1'b1; use_imm = 1'b1; zero_ext = 1'b1; alu_op = ALU_AND; end
            6'h0D: begin reg_we = 1'b1; use_imm = 1'b1; zero_ext = 1'b1; alu_op = ALU_OR; end
            6'h23: begin reg_we = 1'b1; use_imm = 1'b1; is_load = 1'b1; end
            6'h2B: begin mem_we = 1'b1; use_imm = 1'b1; end
            6'h04: branch = (rs_val == rt_val);
            6'h05: branch = (rs_val != rt_val);
            6'h02: jump = 1'b1;
            default: ;
        endcase
    end

    mips_regfile rbank (
        .clk(clk), .rst_n(rst_n), .ra1(rs), .ra2(rt), .wa(wa),
        .we(reg_we), .wd(wd), .rd1(rs_val), .rd2(rt_val)
    );

    assign src_b = use_imm ? (zero_ext ? imm_z : imm_s) : rt_val;
    assign alu_y = alu(alu_op, rs_val, src_b);

    mips_dmem #(.DEPTH(DMEM_DEPTH)) dmem (
        .clk(clk), .we(mem_we), .addr(alu_y), .wd(rt_val), .rd(mem_rd)
    );

    assign wd        = is_load ? mem_rd : alu_y;
    assign writedata = rt_val;

    assign pc_plus4 = pc + 32'd4;
    assign pc_next  = jump   ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                      branch ? pc_plus4 + {imm_s[29:0], 2'b00} :
                               pc_plus4;
endmodule

module mips_cpu #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] writedata
);
    mips_datapath #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dpath (
        .clk(clk), .rst_n(reset), .writedata(writedata)
    );
endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: directed programs plus random straight-line programs, checked every
// cycle against an instruction-level interpreter of the KGP-RISC subset.

module tb_mips_cpu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] writedata;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] prog  [64];
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [64];
    bit          m_known [64];
    logic [31:0] m_pc;

    mips_cpu dut (.clk(clk), .reset(reset), .writedata(writedata));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] jtype(int word);
        return {6'h02, 26'(word)};
    endfunction

    task automatic m_wr(input int r, input logic [31:0] v);
        if (r != 0) m_reg[r] = v;
    endtask

    task automatic m_reset();
        m_pc = 32'd0;
        for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
    endtask

    // Architectural interpreter: one instruction per call, straight from the ISA rules.
    task automatic m_step();
        logic [31:0] ins, a, b, se, addr, nxt;
        int op, fn, rs, rt, rd, idx;
        ins  = prog[int'((m_pc >> 2) % 64)];
        op   = int'(ins[31:26]);
        rs   = int'(ins[25:21]);
        rt   = int'(ins[20:16]);
        rd   = int'(ins[15:11]);
        fn   = int'(ins[5:0]);
        a    = m_reg[rs];
        b    = m_reg[rt];
        se   = {{16{ins[15]}}, ins[15:0]};
        addr = a + se;
        idx  = int'((addr >> 2) % 64);
        nxt  = m_pc + 32'd4;
        case (op)
            'h00: case (fn)
                'h20: m_wr(rd, a + b);
                'h22: m_wr(rd, a - b);
                'h24: m_wr(rd, a & b);
                'h25: m_wr(rd, a | b);
                'h2A: m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                default: ;
            endcase
            'h08: m_wr(rt, a + se);
            'h0C: m_wr(rt, a & {16'h0000, ins[15:0]});
            'h0D: m_wr(rt, a | {16'h0000, ins[15:0]});
            'h23: m_wr(rt, m_mem[idx]);
            'h2B: begin m_mem[idx] = b; m_known[idx] = 1'b1; end
            'h04: if (a == b) nxt = m_pc + 32'd4 + (se << 2);
            'h05: if (a != b) nxt = m_pc + 32'd4 + (se << 2);
            'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) dut.dpath.imem.imem[i] = prog[i];
    endtask

    // Called away from the clock edge; compares, clocks once, steps the model.
    task automatic run_cycles(input string tag, input int n);
        logic [31:0] ins;
        for (int i = 0; i < n; i++) begin
            ins = prog[int'((m_pc >> 2) % 64)];
            check($sformatf("%s pc c%0d", tag, i), dut.dpath.pc, m_pc);
            check($sformatf("%s writedata c%0d", tag, i), writedata, m_reg[int'(ins[20:16])]);
            @(posedge clk);
            m_step();
            @(negedge clk);
        end
    endtask

    task automatic compare_state(input string tag);
        for (int r = 0; r < 32; r++)
            check($sformatf("%s r%0d", tag, r), dut.dpath.rbank.regfile[r], m_reg[r]);
        for (int k = 0; k < 64; k++)
            if (m_known[k]) check($sformatf("%s dmem%0d", tag, k), dut.dpath.dmem.dmem[k], m_mem[k]);
    endtask

    task automatic restart();
        @(negedge clk);
        reset = 1'b0;
        load_prog();
        m_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_gcd(input string tag);
        check({tag, " dmem2"}, dut.dpath.dmem.dmem[2], 32'd6);
        check({tag, " dmem0"}, dut.dpath.dmem.dmem[0], 32'd12);
        check({tag, " dmem1"}, dut.dpath.dmem.dmem[1], 32'd18);
        check({tag, " r1"}, dut.dpath.rbank.regfile[1], 32'd6);
        check({tag, " r2"}, dut.dpath.rbank.regfile[2], 32'd6);
    endtask

    initial begin
        int sel, rs, rt, rd, k, off;
        logic [31:0] u;
        for (int i = 0; i < 64; i++) begin m_mem[i] = 32'd0; m_known[i] = 1'b0; end

        // Directed program: arithmetic, logic, compare, memory, control flow, NOPs.
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        prog[0]  = itype('h08, 0, 1, 5);
        prog[1]  = itype('h08, 0, 2, 7);
        prog[2]  = rtype(1, 2, 3, 'h20);
        prog[3]  = rtype(2, 1, 4, 'h22);
        prog[4]  = rtype(1, 2, 3, 'h24);
        prog[5]  = rtype(1, 2, 4, 'h25);
        prog[6]  = rtype(1, 2, 5, 'h2A);
        prog[7]  = rtype(2, 1, 6, 'h2A);
        prog[8]  = itype('h08, 0, 7, -1);
        prog[9]  = rtype(7, 0, 8, 'h2A);
        prog[10] = rtype(1, 2, 3, 'h20);
        prog[11] = itype('h2B, 0, 3, 28);
        prog[12] = itype('h23, 0, 9, 28);
        prog[13] = itype('h04, 1, 1, 1);
        prog[14] = itype('h08, 0, 10, 1);
        prog[15] = itype('h05, 1, 1, 1);
        prog[16] = itype('h08, 0, 11, 2);
        prog[17] = jtype(20);
        prog[18] = itype('h08, 0, 12, 3);
        prog[19] = itype('h08, 0, 12, 4);
        prog[20] = itype('h08, 0, 13, 9);
        prog[21] = itype('h3F, 1, 18, 5);
        prog[22] = rtype(1, 2, 14, 'h3F);
        prog[23] = itype('h0D, 0, 15, 'h8001);
        prog[24] = itype('h0C, 7, 16, 'h8000);
        prog[25] = itype('h08, 0, 17, 'h8000);
        prog[26] = itype('h08, 0, 0, 5);
        load_prog();
        m_reset();
        repeat (2) @(negedge clk);
        check("reset pc", dut.dpath.pc, 32'd0);
        check("reset writedata", writedata, 32'd0);
        check("reset r1", dut.dpath.rbank.regfile[1], 32'd0);
        reset = 1'b1;

        run_cycles("arith", 4);
        check("arith r1", dut.dpath.rbank.regfile[1], 32'd5);
        check("arith r2", dut.dpath.rbank.regfile[2], 32'd7);
        check("arith r3", dut.dpath.rbank.regfile[3], 32'd12);
        check("arith r4", dut.dpath.rbank.regfile[4], 32'd2);
        run_cycles("logic", 4);
        check("and r3", dut.dpath.rbank.regfile[3], 32'd5);
        check("or r4", dut.dpath.rbank.regfile[4], 32'd7);
        check("slt r5", dut.dpath.rbank.regfile[5], 32'd1);
        check("slt r6", dut.dpath.rbank.regfile[6], 32'd0);
        run_cycles("signed", 3);
        check("addi r7", dut.dpath.rbank.regfile[7], 32'hFFFF_FFFF);
        check("slt signed r8", dut.dpath.rbank.regfile[8], 32'd1);
        check("sw writedata", writedata, 32'd12);
        run_cycles("mem", 2);
        check("sw dmem7", dut.dpath.dmem.dmem[7], 32'd12);
        check("lw r9", dut.dpath.rbank.regfile[9], 32'd12);
        run_cycles("flow", 8);
        check("beq skip r10", dut.dpath.rbank.regfile[10], 32'd0);
        check("bne fall r11", dut.dpath.rbank.regfile[11], 32'd2);
        check("j skip r12", dut.dpath.rbank.regfile[12], 32'd0);
        check("j target r13", dut.dpath.rbank.regfile[13], 32'd9);
        run_cycles("misc", 6);
        check("undef op r18", dut.dpath.rbank.regfile[18], 32'd0);
        check("undef funct r14", dut.dpath.rbank.regfile[14], 32'd0);
        check("ori zext r15", dut.dpath.rbank.regfile[15], 32'h0000_8001);
        check("andi zext r16", dut.dpath.rbank.regfile[16], 32'h0000_8000);
        check("addi sext r17", dut.dpath.rbank.regfile[17], 32'hFFFF_8000);
        check("r0 write ignored", dut.dpath.rbank.regfile[0], 32'd0);
        compare_state("directed");

        // GCD(12, 18) by repeated subtraction.
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        prog[0]  = itype('h08, 0, 1, 12);
        prog[1]  = itype('h08, 0, 2, 18);
        prog[2]  = itype('h2B, 0, 1, 0);
        prog[3]  = itype('h2B, 0, 2, 4);
        prog[4]  = itype('h04, 1, 2, 6);
        prog[5]  = rtype(1, 2, 3, 'h2A);
        prog[6]  = itype('h04, 3, 0, 2);
        prog[7]  = rtype(2, 1, 2, 'h22);
        prog[8]  = jtype(4);
        prog[9]  = rtype(1, 2, 1, 'h22);
        prog[10] = jtype(4);
        prog[11] = itype('h2B, 0, 1, 8);
        prog[12] = jtype(12);
        restart();
        run_cycles("gcd", 40);
        check_gcd("gcd");
        compare_state("gcd");

        // Asynchronous reset mid-run: no clock edge between assertion and the checks.
        run_cycles("gcd tail", 3);
        #2 reset = 1'b0;
        #1;
        check("async pc", dut.dpath.pc, 32'd0);
        check("async r1", dut.dpath.rbank.regfile[1], 32'd0);
        check("async r2", dut.dpath.rbank.regfile[2], 32'd0);
        check("async writedata", writedata, 32'd0);
        check("async dmem2 kept", dut.dpath.dmem.dmem[2], 32'd6);
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        run_cycles("gcd rerun", 40);
        check_gcd("gcd rerun");

        // Random straight-line programs; memory offsets also exercise index wraparound.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) prog[i] = itype('h2B, 0, 0, 4 * i);
            for (int i = 8; i < 48; i++) begin
                sel = $urandom_range(0, 12);
                rs  = $urandom_range(0, 7);
                rt  = $urandom_range(0, 7);
                rd  = $urandom_range(0, 7);
                u   = $urandom();
                k   = $urandom_range(0, 7);
                off = 4 * k;
                case ($urandom_range(0, 2))
                    1: off = off + 256;
                    2: off = off - 256;
                    default: ;
                endcase
                case (sel)
                    0: prog[i] = rtype(rs, rt, rd, 'h20);
                    1: prog[i] = rtype(rs, rt, rd, 'h22);
                    2: prog[i] = rtype(rs, rt, rd, 'h24);
                    3: prog[i] = rtype(rs, rt, rd, 'h25);
                    4: prog[i] = rtype(rs, rt, rd, 'h2A);
                    5: prog[i] = itype('h08, rs, rt, int'(u[15:0]));
                    6: prog[i] = itype('h0C, rs, rt, int'(u[15:0]));
                    7: prog[i] = itype('h0D, rs, rt, int'(u[15:0]));
                    8: prog[i] = itype('h23, 0, rt, off);
                    9: prog[i] = itype('h2B, 0, rt, off);
                    10: prog[i] = itype(u[16] ? 'h05 : 'h04, rs, rt, $urandom_range(0, 3));
                    11: prog[i] = {6'h3F, u[25:0]};
                    default: prog[i] = rtype(rs, rt, rd, 0);
                endcase
            end
            for (int i = 48; i < 64; i++) prog[i] = jtype(48);
            restart();
            run_cycles($sformatf("rand%0d", p), 52);
            compare_state($sformatf("rand%0d", p));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
